// File: rtl/logic_unit_pkg.sv
// Shared types for the handshaked logic responder: opcode encoding,
// responder FSM states and the completed-transaction counter width.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_PASS_A = 3'd7
    } logic_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } lu_state_e;

    localparam int LU_COUNT_W = 16;

endpackage

// File: rtl/logic_unit_alu.sv
// Purely combinational opcode-to-result bitwise function with zero detect.
// The zero flag is taken from the final result, after any inversion.
module logic_unit_alu
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    // Select the bitwise function; B is ignored for the single-operand ops.
    always_comb begin
        result_o = a_i;
        case (logic_op_e'(op_i))
            OP_AND:    result_o = a_i & b_i;
            OP_OR:     result_o = a_i | b_i;
            OP_XOR:    result_o = a_i ^ b_i;
            OP_NAND:   result_o = ~(a_i & b_i);
            OP_NOR:    result_o = ~(a_i | b_i);
            OP_XNOR:   result_o = ~(a_i ^ b_i);
            OP_NOT_A:  result_o = ~a_i;
            OP_PASS_A: result_o = a_i;
            default:   result_o = a_i;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/logic_unit_resp.sv
// Handshaked bitwise logic responder: IDLE accepts a request, EXEC computes
// from the captured operands, RESP presents a held result until taken.
// Optional feature macro: LOGIC_UNIT_RESP_COUNT_EN adds the saturating
// txn_count output counting completed response handshakes.
module logic_unit_resp
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [WIDTH-1:0]      req_a,
    input  logic [WIDTH-1:0]      req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero
`ifdef LOGIC_UNIT_RESP_COUNT_EN
    ,
    output logic [LU_COUNT_W-1:0] txn_count
`endif
);

    lu_state_e        state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             accept;

    // Handshake outputs come straight from the registered state.
    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign accept     = req_ready && req_valid;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

    // FSM state register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: one cycle each in IDLE-accept, EXEC and RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept only; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    logic_unit_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Response registers load in EXEC and hold through RESP backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
        end
    end

`ifdef LOGIC_UNIT_RESP_COUNT_EN
    logic [LU_COUNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d     = (cnt_q == {LU_COUNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign txn_count = cnt_q;

    // Completed-handshake counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      cnt_q <= '0;
        else if (rsp_valid && rsp_ready) cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_logic_unit_resp.sv
// Self-checking bench for logic_unit_resp: directed and randomized
// transactions compared against a behavioural bitwise model.
module tb_logic_unit_resp;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
`ifdef LOGIC_UNIT_RESP_COUNT_EN
    logic [15:0]  txn_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_unit_resp #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
`ifdef LOGIC_UNIT_RESP_COUNT_EN
        ,
        .txn_count  (txn_count)
`endif
    );

    // Reference: the opcode table from the block description.
    function automatic logic [W-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return ~a;
            default: return a;
        endcase
    endfunction

    // Drive one transaction; hold = cycles of rsp_ready low once valid.
    // Returns observed result/zero, latency in negedges from accept,
    // whether the result stayed stable under backpressure, and timeout.
    task automatic do_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output logic [W-1:0] res, output logic z,
                          output int lat, output bit stable, output bit to);
        int n;
        to = 0; stable = 1; lat = 0; res = '0; z = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin to = 1; req_valid = 1'b0; return; end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = W'($urandom); req_b = W'($urandom); req_op = 3'($urandom);
        if (hold == 0) rsp_ready = 1'b1;   // early ready must not shortcut EXEC
        while (lat < 20) begin
            @(negedge clk); lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin to = 1; rsp_ready = 1'b0; return; end
        res = rsp_result; z = rsp_zero;
        for (int i = 0; i < hold; i++) begin
            req_a = W'($urandom); req_b = W'($urandom);
            @(negedge clk);
            if (rsp_result !== res || rsp_zero !== z || !rsp_valid || req_ready) stable = 0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 4'h0 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b res=%b z=%b, want 1 0 0000 0",
                     req_ready, rsp_valid, rsp_result, rsp_zero);
        end
`ifdef LOGIC_UNIT_RESP_COUNT_EN
        checks++;
        if (txn_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", txn_count);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] r; logic z; int lat; bit st, to;
        logic [2:0]   ops [4] = '{3'd1, 3'd1, 3'd2, 3'd1};
        logic [W-1:0] as  [4] = '{4'b1001, 4'b0011, 4'b1111, 4'b0000};
        logic [W-1:0] bs  [4] = '{4'b0101, 4'b1100, 4'b1111, 4'b0000};
        logic [W-1:0] exp_r [4] = '{4'b1101, 4'b1111, 4'b0000, 4'b0000};
        logic         exp_z [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_txn(ops[i], as[i], bs[i], i, r, z, lat, st, to);
            checks++;
            if (to) begin errors++; $display("FAIL directed_%0d_timeout: got timeout want response", i); end
            checks++;
            if (r !== exp_r[i] || z !== exp_z[i]) begin
                errors++; $display("FAIL directed_%0d: got res=%b z=%b want res=%b z=%b", i, r, z, exp_r[i], exp_z[i]);
            end
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL directed_%0d_latency: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_all_ops();
        logic [W-1:0] r; logic z; int lat; bit st, to;
        logic [W-1:0] exp_r [8] = '{4'b0010, 4'b1110, 4'b1100, 4'b1101, 4'b0001, 4'b0011, 4'b0101, 4'b1010};
        for (int op = 0; op < 8; op++) begin
            do_txn(3'(op), 4'b1010, 4'b0110, 0, r, z, lat, st, to);
            checks++;
            if (to || r !== exp_r[op] || z !== 1'b0) begin
                errors++; $display("FAIL all_ops_%0d: got res=%b z=%b to=%0d want res=%b z=0", op, r, z, to, exp_r[op]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r; logic z; int lat; bit st, to;
        do_txn(3'd2, 4'b0110, 4'b0101, 5, r, z, lat, st, to);
        checks++;
        if (to || r !== 4'b0011 || z !== 1'b0) begin
            errors++; $display("FAIL backpressure_result: got res=%b z=%b to=%0d want 0011 0", r, z, to);
        end
        checks++;
        if (!st) begin errors++; $display("FAIL backpressure_stable: got unstable/ready high want stable"); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure_complete: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r; logic z; int lat; bit st, to; bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_a = 4'b0001; req_b = 4'b0001;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);   // in EXEC
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 4'h0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL reset_mid_async: got rdy=%b vld=%b res=%b z=%b want 1 0 0000 0",
                               req_ready, rsp_valid, rsp_result, rsp_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp_valid) seen = 1; end
        checks++;
        if (seen || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_noresp: got vld_seen=%0d rdy=%b want 0 1", seen, req_ready);
        end
        do_txn(3'd1, 4'b0001, 4'b0010, 0, r, z, lat, st, to);
        checks++;
        if (to || r !== 4'b0011 || z !== 1'b0) begin
            errors++; $display("FAIL reset_mid_next: got res=%b z=%b to=%0d want 0011 0", r, z, to);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, a, b, e; logic z; int lat, op; bit st, to;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = W'($urandom); b = W'($urandom);
            e  = model(op, a, b);
            do_txn(3'(op), a, b, int'($urandom_range(0, 3)), r, z, lat, st, to);
            checks++;
            if (to || r !== e || z !== (e == '0) || lat !== 2 || !st) begin
                errors++;
                $display("FAIL random_%0d: op=%0d a=%b b=%b got res=%b z=%b lat=%0d st=%0d to=%0d want res=%b z=%b lat=2",
                         i, op, a, b, r, z, lat, st, to, e, (e == '0));
            end
        end
    endtask

`ifdef LOGIC_UNIT_RESP_COUNT_EN
    task automatic test_count();
        logic [W-1:0] r; logic z; int lat; bit st, to;
        @(negedge clk); rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) do_txn(3'd0, 4'hF, 4'h3, 0, r, z, lat, st, to);
        @(negedge clk);
        checks++;
        if (txn_count !== 16'd3) begin errors++; $display("FAIL count_three: got %0d want 3", txn_count); end
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        for (int i = 0; i < 3; i++) do_txn(3'd1, 4'h1, 4'h2, 0, r, z, lat, st, to);
        @(negedge clk);
        checks++;
        if (txn_count !== 16'hFFFF) begin errors++; $display("FAIL count_saturate: got %h want ffff", txn_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_all_ops();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef LOGIC_UNIT_RESP_COUNT_EN
        test_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
